// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// The address width and depth defaults match Instruction_memory so the
// loader and the memory stay in agreement when either is resized.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_WIDTH = 8;
  localparam int unsigned IMEM_DEPTH      = 256;

  // Running checksum type: a plain XOR of every data byte
  typedef logic [7:0] csum_t;

  // Loader sequencing states, in stream order
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  // States in which the loader consumes bytes from the stream
  function automatic logic accepts_bytes(input state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
// The first three bytes of a word sit in a shift register; the fourth byte
// is combined directly so the full word and its valid pulse appear in the
// same cycle the fourth byte is accepted.
module byte_to_word_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  input  logic [1:0]  byte_cnt_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q;
  logic [23:0] shift_d;

  // Shift each accepted byte in; clearing wins over shifting
  always_comb begin
    shift_d = shift_q;
    if (clear_i) begin
      shift_d = '0;
    end else if (strobe_i) begin
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  // Shift register state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = strobe_i && (byte_cnt_i == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader for the MIPS-32 instruction memory.
// Parses a length-prefixed, XOR-checksummed byte stream, writes each word
// into instruction memory and keeps the CPU in reset until the image has
// been verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = IMEM_DEPTH
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] DepthW = 17'(DEPTH);

  state_e                state_q, state_d;
  logic [7:0]            lenHi_q, lenHi_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           wordCnt_q, wordCnt_d;
  logic [1:0]            byteCnt_q, byteCnt_d;
  csum_t                 csum_q, csum_d;
  logic                  memWe_q, memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [31:0]           memWdata_q, memWdata_d;

  logic                  accept;
  logic                  packStrobe;
  logic                  packClear;
  logic [31:0]           packWord;
  logic                  packValid;
  logic [15:0]           lenNext;

  byte_to_word_packer u_packer (
    .clk_i        (Clk),
    .reset_i      (reset),
    .byte_i       (in_byte),
    .strobe_i     (packStrobe),
    .clear_i      (packClear),
    .byte_cnt_i   (byteCnt_q),
    .word_o       (packWord),
    .word_valid_o (packValid)
  );

  // Status outputs are pure decodes of the registered state
  assign in_ready  = accepts_bytes(state_q);
  assign busy      = accepts_bytes(state_q);
  assign cpu_reset = accepts_bytes(state_q) || (state_q == ERROR);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERROR);
  assign accept    = in_valid && in_ready;
  assign lenNext   = {lenHi_q, in_byte};

  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;

  // Next-state logic: stream parsing, counters, checksum and write port
  always_comb begin
    state_d    = state_q;
    lenHi_d    = lenHi_q;
    len_d      = len_q;
    wordCnt_d  = wordCnt_q;
    byteCnt_d  = byteCnt_q;
    csum_d     = csum_q;
    packStrobe = 1'b0;
    packClear  = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = LEN_HI;
          wordCnt_d = '0;
          byteCnt_d = '0;
          csum_d    = '0;
          packClear = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) begin
          lenHi_d = in_byte;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = lenNext;
          if (lenNext == 16'd0) begin
            state_d = CHECK;
          end else if ({1'b0, lenNext} > DepthW) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          packStrobe = 1'b1;
          csum_d     = csum_q ^ in_byte;
          byteCnt_d  = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            wordCnt_d = wordCnt_q + 16'd1;
            if (wordCnt_q == (len_q - 16'd1)) begin
              state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (accept) begin
          state_d = (in_byte == csum_q) ? DONE : ERROR;
        end
      end
      default: state_d = IDLE;
    endcase

    memWe_d    = packValid;
    memAddr_d  = packValid ? wordCnt_q[ADDR_WIDTH-1:0] : memAddr_q;
    memWdata_d = packValid ? packWord : memWdata_q;
  end

  // State register; reset abandons any load in progress and pending write
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lenHi_q    <= '0;
      len_q      <= '0;
      wordCnt_q  <= '0;
      byteCnt_q  <= '0;
      csum_q     <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lenHi_q    <= lenHi_d;
      len_q      <= len_d;
      wordCnt_q  <= wordCnt_d;
      byteCnt_q  <= byteCnt_d;
      csum_q     <= csum_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        Clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int   checks;
  int   errors;
  int   weCount;
  wr_t  sb[$];
  logic [7:0] csum;

  imem_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // 10 ns clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest scoreboard entry
  always @(negedge Clk) begin
    if (mem_we === 1'b1) begin
      weCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
        checkOutput("wr_data", mem_wdata, e.data);
      end
    end
  end

  // Offer one byte, optionally after idle gap cycles, until it is accepted
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    logic acc;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge Clk); #1;
    end
    in_byte  = b;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge Clk);
      acc = in_ready;
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Queue the expected write, then stream the word MSB first
  task automatic sendWord(input logic [7:0] addr, input logic [31:0] w, input int gap);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb.push_back(e);
    for (int k = 3; k >= 0; k--) begin
      csum = csum ^ w[k*8 +: 8];
      applyStimulus(w[k*8 +: 8], gap);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    csum  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    int wBefore;
    logic [31:0] w;
    checks   = 0;
    errors   = 0;
    weCount  = 0;
    csum     = 8'h00;
    reset    = 1'b1;
    start    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    idleCycles(3);
    reset = 1'b0;
    @(negedge Clk);
    checkOutput("rst_outputs", {25'd0, in_ready, mem_we, busy, done, error, cpu_reset, 1'b0}, 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    @(posedge Clk); #1;

    $display("[TB] single word load");
    pulseStart();
    @(negedge Clk);
    checkOutput("load_busy", {30'd0, busy, cpu_reset}, 32'h3);
    @(posedge Clk); #1;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    sendWord(8'd0, 32'h2008_0005, 0);
    checkOutput("write_latency", 32'(mem_we), 32'd1);
    checkOutput("cpu_reset_before_csum", 32'(cpu_reset), 32'd1);
    applyStimulus(csum, 0);
    checkOutput("t1_status", {28'd0, done, error, busy, cpu_reset}, 32'h8);
    idleCycles(2);
    checkOutput("t1_writes", 32'(weCount), 32'd1);

    $display("[TB] two words with toggling valid");
    pulseStart();
    applyStimulus(8'h00, 1);
    applyStimulus(8'h02, 1);
    sendWord(8'd0, 32'h2008_0005, 1);
    sendWord(8'd1, 32'h0000_0000, 1);
    checkOutput("t2_csum_model", 32'(csum), 32'h2D);
    applyStimulus(8'h2D, 1);
    checkOutput("t2_status", {28'd0, done, error, busy, cpu_reset}, 32'h8);
    idleCycles(2);
    checkOutput("t2_writes", 32'(weCount), 32'd3);

    $display("[TB] bad checksum");
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h02, 0);
    sendWord(8'd0, 32'h2008_0005, 0);
    sendWord(8'd1, 32'h0000_0000, 0);
    applyStimulus(8'h2C, 0);
    checkOutput("t3_status", {28'd0, done, error, busy, cpu_reset}, 32'h5);
    idleCycles(2);
    checkOutput("t3_writes", 32'(weCount), 32'd5);

    $display("[TB] oversize length");
    wBefore = weCount;
    pulseStart();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    checkOutput("t4_status", {28'd0, done, error, busy, cpu_reset}, 32'h5);
    in_byte  = 8'h55;
    in_valid = 1'b1;
    idleCycles(3);
    @(negedge Clk);
    checkOutput("t4_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge Clk); #1;
    checkOutput("t4_writes", 32'(weCount), 32'(wBefore));

    $display("[TB] start with in_valid, empty image");
    in_byte  = 8'hFF;
    in_valid = 1'b1;
    pulseStart();
    in_valid = 1'b0;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("t5_status", {28'd0, done, error, busy, cpu_reset}, 32'h8);
    checkOutput("t5_writes", 32'(weCount), 32'(wBefore));

    $display("[TB] reset mid-load");
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h08, 0);
    reset = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    @(negedge Clk);
    checkOutput("t6_status", {27'd0, in_ready, done, error, busy, cpu_reset}, 32'h0);
    idleCycles(4);
    checkOutput("t6_writes", 32'(weCount), 32'(wBefore));

    $display("[TB] start held during load");
    pulseStart();
    start = 1'b1;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    csum = 8'h00;
    sb.push_back('{addr: 8'd0, data: 32'h2008_0005});
    applyStimulus(8'h20, 0);
    applyStimulus(8'h08, 0);
    applyStimulus(8'h00, 0);
    start = 1'b0;
    applyStimulus(8'h05, 0);
    checkOutput("t7_busy", 32'(busy), 32'd1);
    applyStimulus(8'h2D, 0);
    checkOutput("t7_status", {28'd0, done, error, busy, cpu_reset}, 32'h8);
    idleCycles(3);
    checkOutput("t7_done_held", 32'(done), 32'd1);
    checkOutput("t7_writes", 32'(weCount), 32'(wBefore + 1));

    $display("[TB] full depth load");
    pulseStart();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i), 8'hA5, 8'(i * 3)};
      sendWord(8'(i), w, 0);
    end
    checkOutput("t8_last_addr", 32'(mem_addr), 32'd255);
    applyStimulus(csum, 0);
    checkOutput("t8_status", {28'd0, done, error, busy, cpu_reset}, 32'h8);
    idleCycles(2);
    checkOutput("t8_writes", 32'(weCount), 32'(wBefore + 257));
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
